// File: rtl/shot_scheduler.sv
`default_nettype none
// shot_scheduler -- player bullet slot pool: fire allocation, per-frame advance, registered pixel flag. Rev 1.0
// Optional build macro SHOT_AUTO_FIRE_EN: fire_req is level-triggered (auto fire) instead of edge-triggered.
module shot_scheduler #(
   parameter int         SLOTS           = 4,
   parameter logic [9:0] STEP            = 10'd4,
   parameter logic [9:0] TOP_LIMIT       = 10'd35,
   parameter logic [9:0] PLAYER_Y        = 10'd400,
   parameter int         COOLDOWN_FRAMES = 8
) (
   input  logic                     clk,
   input  logic                     Reset,
   input  logic                     frame_tick,
   input  logic                     fire_req,
   input  logic [9:0]               x_position_player,
   input  logic                     hit_valid,
   input  logic [$clog2(SLOTS)-1:0] hit_slot,
   input  logic [9:0]               hCount,
   input  logic [9:0]               vCount,
   output logic                     bullet_px,
   output logic [SLOTS-1:0]         active_mask,
   output logic [15:0]              shots_fired
);
   localparam int            IW         = $clog2(SLOTS);
   localparam logic [0:0]    S_IDLE     = 1'b0;
   localparam logic [0:0]    S_UPD      = 1'b1;
   localparam logic [9:0]    c_RETIRE_Y = TOP_LIMIT + STEP;
   localparam logic [7:0]    c_COOLDOWN = 8'(COOLDOWN_FRAMES);
   localparam logic [IW-1:0] c_LAST_IDX = IW'(SLOTS - 1);

   logic [0:0]       r_state;
   logic [IW-1:0]    r_idx;
   logic             r_pending;
   logic [7:0]       r_cool;
   logic [SLOTS-1:0] r_act;
   logic [9:0]       r_bx [SLOTS];
   logic [9:0]       r_by [SLOTS];
   logic             r_px;
   logic [15:0]      r_shots;

   logic             w_fire_set;
   logic             w_service;
   logic             w_accept;
   logic             w_px;
   logic [SLOTS-1:0] w_free;
   logic [SLOTS-1:0] w_alloc;
   logic [SLOTS-1:0] w_hit;

`ifdef SHOT_AUTO_FIRE_EN
   assign w_fire_set = fire_req;
`else
   logic r_fire_d;
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) r_fire_d <= 1'b0;
      else       r_fire_d <= fire_req;
   end
   assign w_fire_set = fire_req & ~r_fire_d;
`endif

   // Lowest set bit of the free mask picks the lowest-index free slot.
   assign w_free    = ~r_act;
   assign w_alloc   = w_free & (~w_free + {{(SLOTS-1){1'b0}}, 1'b1});
   assign w_service = (r_state == S_IDLE) & r_pending;
   assign w_accept  = w_service & (r_cool == 8'd0) & (|w_free);

   always_comb begin
      w_hit = '0;
      w_px  = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         w_hit[i] = hit_valid & (hit_slot == IW'(i)) & r_act[i];
         if (r_act[i] && (hCount >= r_bx[i]) && ({1'b0, hCount} < {1'b0, r_bx[i]} + 11'd10) &&
             (vCount >= r_by[i]) && ({1'b0, vCount} <= {1'b0, r_by[i]} + 11'd20))
            w_px = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (frame_tick) begin
               r_state <= S_UPD;
               r_idx   <= '0;
            end
            S_UPD: begin
               if (r_idx == c_LAST_IDX) r_state <= S_IDLE;
               else                     r_idx   <= r_idx + IW'(1);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_pending <= 1'b0;
         r_cool    <= 8'd0;
         r_shots   <= 16'd0;
         r_px      <= 1'b0;
      end else begin
         r_pending <= w_fire_set | (r_pending & ~w_service);
         r_px      <= w_px;
         if (w_accept) begin
            r_cool  <= c_COOLDOWN;
            r_shots <= r_shots + 16'd1;
         end else if (frame_tick && (r_cool != 8'd0)) begin
            r_cool <= r_cool - 8'd1;
         end
      end
   end

   // A hit only touches live slots, so it never collides with an allocation.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_act <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            r_bx[i] <= '0;
            r_by[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SLOTS; i++) begin
            if (w_hit[i]) begin
               r_act[i] <= 1'b0;
            end else if (w_accept && w_alloc[i]) begin
               r_act[i] <= 1'b1;
               r_bx[i]  <= x_position_player + 10'd15;
               r_by[i]  <= PLAYER_Y - 10'd21;
            end else if ((r_state == S_UPD) && (r_idx == IW'(i)) && r_act[i]) begin
               if (r_by[i] >= c_RETIRE_Y) r_by[i]  <= r_by[i] - STEP;
               else                       r_act[i] <= 1'b0;
            end
         end
      end
   end

   assign bullet_px   = r_px;
   assign active_mask = r_act;
   assign shots_fired = r_shots;

endmodule
`default_nettype wire

// File: tb/tb_shot_scheduler.sv
`default_nettype none
// tb_shot_scheduler -- directed scenarios plus randomized traffic against a behavioural slot-pool model.
module tb_shot_scheduler;
   localparam int SLOTS     = 4;
   localparam int IW        = 2;
   localparam int STEP      = 4;
   localparam int TOP_LIMIT = 35;
   localparam int PLAYER_Y  = 400;
   localparam int COOLDOWN  = 8;

   logic             clk = 1'b0;
   logic             Reset = 1'b0;
   logic             frame_tick = 1'b0;
   logic             fire_req = 1'b0;
   logic             hit_valid = 1'b0;
   logic [IW-1:0]    hit_slot = '0;
   logic [9:0]       x_position_player = '0;
   logic [9:0]       hCount = '0;
   logic [9:0]       vCount = '0;
   logic             bullet_px;
   logic [SLOTS-1:0] active_mask;
   logic [15:0]      shots_fired;

   int n_checks = 0;
   int n_fail   = 0;

   bit m_act [SLOTS];
   int m_bx  [SLOTS];
   int m_by  [SLOTS];
   bit m_pend, m_fire_prev, m_px;
   int m_cool, m_shots, m_upd;

   shot_scheduler dut (
      .clk(clk), .Reset(Reset), .frame_tick(frame_tick), .fire_req(fire_req),
      .x_position_player(x_position_player), .hit_valid(hit_valid), .hit_slot(hit_slot),
      .hCount(hCount), .vCount(vCount), .bullet_px(bullet_px),
      .active_mask(active_mask), .shots_fired(shots_fired)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < SLOTS; i++) begin
         m_act[i] = 1'b0; m_bx[i] = 0; m_by[i] = 0;
      end
      m_pend = 0; m_fire_prev = 0; m_px = 0; m_cool = 0; m_shots = 0; m_upd = -1;
   endtask

   // One clock of the pool, expressed from the rules: sweep position m_upd (-1 = idle).
   task automatic model_step();
      bit n_act [SLOTS];
      int n_by  [SLOTS];
      bit idle, fire_set, acc;
      int free_slot, h, v, s;
      n_act = m_act;
      n_by  = m_by;
      idle  = (m_upd < 0);
`ifdef SHOT_AUTO_FIRE_EN
      fire_set = fire_req;
`else
      fire_set = fire_req && !m_fire_prev;
`endif
      h = int'(hCount);
      v = int'(vCount);
      m_px = 0;
      for (int i = 0; i < SLOTS; i++)
         if (m_act[i] && h >= m_bx[i] && h < m_bx[i] + 10 && v >= m_by[i] && v <= m_by[i] + 20)
            m_px = 1;
      acc = 0;
      if (idle && m_pend && m_cool == 0) begin
         free_slot = -1;
         for (int i = SLOTS - 1; i >= 0; i--) if (!m_act[i]) free_slot = i;
         if (free_slot >= 0) begin
            n_act[free_slot] = 1;
            m_bx[free_slot]  = (int'(x_position_player) + 15) % 1024;
            n_by[free_slot]  = PLAYER_Y - 21;
            m_shots          = (m_shots + 1) % 65536;
            acc = 1;
         end
      end
      if (acc) m_cool = COOLDOWN;
      else if (frame_tick && m_cool > 0) m_cool = m_cool - 1;
      if (!idle) begin
         s = m_upd;
         if (m_act[s]) begin
            if (m_by[s] >= TOP_LIMIT + STEP) n_by[s] = m_by[s] - STEP;
            else n_act[s] = 0;
         end
         m_upd = (s == SLOTS - 1) ? -1 : s + 1;
      end else if (frame_tick) begin
         m_upd = 0;
      end
      if (hit_valid && m_act[hit_slot]) n_act[hit_slot] = 0;
      m_pend      = fire_set || (m_pend && !idle);
      m_fire_prev = fire_req;
      m_act       = n_act;
      m_by        = n_by;
   endtask

   task automatic tick();
      if (Reset) model_reset();
      else       model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic fire_pulse();
      fire_req = 1'b1; tick();
      fire_req = 1'b0; tick();
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         frame_tick = 1'b1; tick();
         frame_tick = 1'b0;
         repeat (SLOTS) tick();
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) tick();
      Reset = 1'b0;
      for (int c = 0; c <= 100; c++) begin
         n_checks++; if (active_mask !== 4'b0000) begin n_fail++; $display("FAIL reset_mask cycle %0d: got %b expected 0000", c, active_mask); end
         n_checks++; if (shots_fired !== 16'd0) begin n_fail++; $display("FAIL reset_shots cycle %0d: got %0d expected 0", c, shots_fired); end
         n_checks++; if (bullet_px !== 1'b0) begin n_fail++; $display("FAIL reset_px cycle %0d: got %b expected 0", c, bullet_px); end
         tick();
      end
   endtask

   task automatic test_fire();
      int ph [6] = '{315, 314, 324, 325, 315, 315};
      int pv [6] = '{379, 379, 399, 379, 378, 400};
      bit pe [6] = '{1, 0, 1, 0, 0, 0};
      x_position_player = 10'd300;
      fire_req = 1'b1; tick();
      n_checks++; if (active_mask !== 4'b0000) begin n_fail++; $display("FAIL fire_early: got %b expected 0000", active_mask); end
      fire_req = 1'b0; tick();
      n_checks++; if (active_mask !== 4'b0001) begin n_fail++; $display("FAIL fire_mask: got %b expected 0001", active_mask); end
      n_checks++; if (shots_fired !== 16'd1) begin n_fail++; $display("FAIL fire_shots: got %0d expected 1", shots_fired); end
      for (int k = 0; k < 6; k++) begin
         hCount = 10'(ph[k]); vCount = 10'(pv[k]); tick();
         n_checks++; if (bullet_px !== pe[k]) begin n_fail++; $display("FAIL fire_px (%0d,%0d): got %b expected %b", ph[k], pv[k], bullet_px, pe[k]); end
      end
   endtask

   task automatic test_frame_update();
      int ph [4] = '{315, 315, 315, 315};
      int pv [4] = '{367, 366, 387, 388};
      bit pe [4] = '{1, 0, 1, 0};
      frames(3);
      for (int k = 0; k < 4; k++) begin
         hCount = 10'(ph[k]); vCount = 10'(pv[k]); tick();
         n_checks++; if (bullet_px !== pe[k]) begin n_fail++; $display("FAIL move_px (%0d,%0d): got %b expected %b", ph[k], pv[k], bullet_px, pe[k]); end
      end
      frames(82);
      hCount = 10'd315; vCount = 10'd39; tick();
      n_checks++; if (bullet_px !== 1'b1) begin n_fail++; $display("FAIL y39_px: got %b expected 1", bullet_px); end
      frames(1);
      hCount = 10'd315; vCount = 10'd35; tick();
      n_checks++; if (bullet_px !== 1'b1) begin n_fail++; $display("FAIL y35_px: got %b expected 1", bullet_px); end
      n_checks++; if (active_mask !== 4'b0001) begin n_fail++; $display("FAIL y35_mask: got %b expected 0001", active_mask); end
      frames(1);
      n_checks++; if (active_mask !== 4'b0000) begin n_fail++; $display("FAIL retire_mask: got %b expected 0000", active_mask); end
      tick();
      n_checks++; if (bullet_px !== 1'b0) begin n_fail++; $display("FAIL retire_px: got %b expected 0", bullet_px); end
   endtask

   task automatic test_pool_full();
      logic [3:0] em [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
      int         es [5] = '{2, 3, 4, 5, 5};
      hCount = '0; vCount = '0;
      for (int k = 0; k < 5; k++) begin
         x_position_player = 10'(100 * k);
         fire_pulse();
         n_checks++; if (active_mask !== em[k]) begin n_fail++; $display("FAIL pool_mask shot %0d: got %b expected %b", k, active_mask, em[k]); end
         n_checks++; if (shots_fired !== 16'(es[k])) begin n_fail++; $display("FAIL pool_shots shot %0d: got %0d expected %0d", k, shots_fired, es[k]); end
         frames(8);
      end
   endtask

   task automatic test_hit_with_fire();
      fire_req = 1'b1; tick();
      fire_req = 1'b0; hit_valid = 1'b1; hit_slot = 2'd2; tick();
      hit_valid = 1'b0;
      n_checks++; if (active_mask !== 4'b1011) begin n_fail++; $display("FAIL hitfire_mask: got %b expected 1011", active_mask); end
      n_checks++; if (shots_fired !== 16'd5) begin n_fail++; $display("FAIL hitfire_shots: got %0d expected 5", shots_fired); end
      tick(); tick();
      n_checks++; if (active_mask !== 4'b1011) begin n_fail++; $display("FAIL hitfire_dropped: got %b expected 1011", active_mask); end
      fire_pulse();
      n_checks++; if (active_mask !== 4'b1111) begin n_fail++; $display("FAIL reuse_mask: got %b expected 1111", active_mask); end
      n_checks++; if (shots_fired !== 16'd6) begin n_fail++; $display("FAIL reuse_shots: got %0d expected 6", shots_fired); end
   endtask

   task automatic test_cooldown();
      logic [3:0] em [4] = '{4'b1101, 4'b1101, 4'b1101, 4'b1111};
      int         es [4] = '{7, 7, 7, 8};
      int         gap [4] = '{8, 3, 4, 1};
      hit_valid = 1'b1; hit_slot = 2'd0; tick();
      hit_slot = 2'd1; tick();
      hit_valid = 1'b0;
      n_checks++; if (active_mask !== 4'b1100) begin n_fail++; $display("FAIL cool_hits: got %b expected 1100", active_mask); end
      for (int k = 0; k < 4; k++) begin
         frames(gap[k]);
         fire_pulse();
         n_checks++; if (active_mask !== em[k]) begin n_fail++; $display("FAIL cool_mask step %0d: got %b expected %b", k, active_mask, em[k]); end
         n_checks++; if (shots_fired !== 16'(es[k])) begin n_fail++; $display("FAIL cool_shots step %0d: got %0d expected %0d", k, shots_fired, es[k]); end
      end
   endtask

   task automatic test_reset_mid_update();
      frame_tick = 1'b1; tick();
      frame_tick = 1'b0; tick();
      Reset = 1'b1; model_reset();
      #1;
      n_checks++; if (active_mask !== 4'b0000) begin n_fail++; $display("FAIL midreset_mask: got %b expected 0000", active_mask); end
      n_checks++; if (shots_fired !== 16'd0) begin n_fail++; $display("FAIL midreset_shots: got %0d expected 0", shots_fired); end
      n_checks++; if (bullet_px !== 1'b0) begin n_fail++; $display("FAIL midreset_px: got %b expected 0", bullet_px); end
      tick();
      Reset = 1'b0; tick();
      x_position_player = 10'd100;
      fire_pulse();
      n_checks++; if (active_mask !== 4'b0001) begin n_fail++; $display("FAIL postreset_mask: got %b expected 0001", active_mask); end
      n_checks++; if (shots_fired !== 16'd1) begin n_fail++; $display("FAIL postreset_shots: got %0d expected 1", shots_fired); end
      hCount = 10'd115; vCount = 10'd379; tick();
      n_checks++; if (bullet_px !== 1'b1) begin n_fail++; $display("FAIL postreset_px: got %b expected 1", bullet_px); end
   endtask

   task automatic test_random();
      logic [SLOTS-1:0] exp_mask;
      int s;
      for (int c = 0; c < 4000; c++) begin
         frame_tick = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 7) == 0) fire_req = ~fire_req;
         hit_valid = ($urandom_range(0, 14) == 0);
         hit_slot  = IW'($urandom_range(0, SLOTS - 1));
         x_position_player = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 1) == 1) begin
            s = int'($urandom_range(0, SLOTS - 1));
            hCount = 10'(m_bx[s] + int'($urandom_range(0, 13)) - 2);
            vCount = 10'(m_by[s] + int'($urandom_range(0, 24)) - 2);
         end else begin
            hCount = 10'($urandom_range(0, 1023));
            vCount = 10'($urandom_range(0, 1023));
         end
         tick();
         for (int i = 0; i < SLOTS; i++) exp_mask[i] = m_act[i];
         n_checks++; if (active_mask !== exp_mask) begin n_fail++; $display("FAIL rand_mask cycle %0d: got %b expected %b", c, active_mask, exp_mask); end
         n_checks++; if (shots_fired !== 16'(m_shots)) begin n_fail++; $display("FAIL rand_shots cycle %0d: got %0d expected %0d", c, shots_fired, m_shots); end
         n_checks++; if (bullet_px !== m_px) begin n_fail++; $display("FAIL rand_px cycle %0d: got %b expected %b", c, bullet_px, m_px); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fire();
      test_frame_update();
      test_pool_full();
      test_hit_with_fire();
      test_cooldown();
      test_reset_mid_update();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
